regfile_bypass: RTL and testbench
=================================

REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 SHALL provide parameter ADDRSIZE, default 5, the number of address bits per register index.
REQ-002 SHALL provide parameter WORDSIZE, default 64, the register width in bits.
REQ-003 SHALL provide parameter NREAD, default 2, the number of read ports (range 1..4).
REQ-004 SHALL provide parameter ZERO_REG, default 1; when 1, entry 0 is hardwired to zero.
REQ-005 SHALL provide parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to the read ports.
REQ-006 SHALL have one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 clr_req  in  1  request to zero the whole file.
REQ-010 ready  out  1  file is in RUN and accepting writes.
REQ-011 regwr  in  1  write enable.
REQ-012 rd  in  ADDRSIZE  write index.
REQ-013 rddata  in  WORDSIZE  write data.
REQ-014 rs_addr  in  NREAD*ADDRSIZE  read indices; port k occupies bits [k*ADDRSIZE +: ADDRSIZE].
REQ-015 rs_data  out  NREAD*WORDSIZE  read data; port k occupies bits [k*WORDSIZE +: WORDSIZE].

Function
REQ-016 SHALL contain RFSIZE = 2^ADDRSIZE entries of WORDSIZE bits.
REQ-017 SHALL implement a two-state FSM with states CLEAR and RUN.
REQ-018 In CLEAR, each cycle SHALL write zero to entry clr_cnt and then increment clr_cnt, which is ADDRSIZE bits wide.
REQ-019 CLEAR SHALL move to RUN on the edge that clears entry RFSIZE-1, so a clear takes exactly RFSIZE cycles; clr_cnt then wraps to 0.
REQ-020 In RUN, clr_req=1 SHALL move the FSM to CLEAR on the next edge with clr_cnt=0.
REQ-021 clr_req during CLEAR SHALL be ignored; the sweep does not restart.
REQ-022 ready SHALL be 1 only in RUN and SHALL be a registered output.
REQ-023 In RUN, regwr=1 SHALL write rddata into entry rd at the rising edge.
REQ-024 A write in the same cycle as an accepted clr_req SHALL be dropped; clear wins.
REQ-025 Writes in CLEAR SHALL be dropped.
REQ-026 When ZERO_REG=1, writes to rd=0 SHALL be discarded and reads of index 0 SHALL return 0.
REQ-027 Reads SHALL be combinational, with zero latency.
REQ-028 When BYPASS=1 and the FSM is in RUN with regwr=1, rs_addr[k]==rd, and the ZERO_REG exception not applying, rs_data[k] SHALL equal rddata.
REQ-029 When BYPASS=0, reads SHALL return the stored value; new data becomes visible the cycle after the write.
REQ-030 In CLEAR, every rs_data port SHALL read 0.
REQ-031 Multiple read ports addressing the same index SHALL return identical data.

Reset
REQ-032 rst_n low SHALL asynchronously force state=CLEAR, clr_cnt=0 and ready=0.
REQ-033 The storage array SHALL NOT be reset directly; the CLEAR sweep zeroes it after rst_n releases.
REQ-034 Reset asserted mid-sweep or mid-write SHALL restart the sweep from entry 0, with no partial write committed.

Structure
REQ-035 The FSM state encoding (CLEAR, RUN) SHALL live in the shared package regfile_pkg.
REQ-036 The default widths SHALL also live in regfile_pkg as XLEN=64 and REGADDR=5.
REQ-037 Read ports SHALL be produced by NREAD instances of a single sub-module, regfile_rdport, containing the bypass and zero mux.

Verification
REQ-038 Reset sweep: release rst_n -> ready=0 for exactly 32 cycles, then 1; all reads return 0.
REQ-039 Write/read: write x5=64'hDEAD_BEEF_0123_4567; next cycle rs_addr port0=5 -> same value; port1=6 -> 0.
REQ-040 Bypass: in the same cycle regwr=1, rd=7, rddata=64'h55, with port1 addr=7 -> port1 reads 64'h55 combinationally; with BYPASS=0 the read returns the old value 0.
REQ-041 x0: write rd=0, rddata=64'hFF -> reads of index 0 return 0 on all ports.
REQ-042 Clear collision: in RUN, clr_req=1 together with a write to x3=64'h9 -> ready=0 next cycle; after 32 cycles ready=1 and x3 reads 0.
REQ-043 Mid-sweep reset: assert rst_n low at clear cycle 10, release it -> a full 32-cycle sweep before ready=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the bypassing register file: default widths and FSM encoding.
package regfile_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned REGADDR = 5;

    // CLEAR sweeps the array to zero; RUN accepts writes.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: zero-register mux, same-cycle write bypass, CLEAR masking.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned ADDRSIZE = REGADDR,
    parameter int unsigned WORDSIZE = XLEN,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                run,
    input  logic [ADDRSIZE-1:0] addr,
    input  logic                wr_en,
    input  logic [ADDRSIZE-1:0] wr_addr,
    input  logic [WORDSIZE-1:0] wr_data,
    input  logic [WORDSIZE-1:0] mem_data,
    output logic [WORDSIZE-1:0] data
);

    // Priority: CLEAR reads zero, then x0, then forwarded write data, then storage.
    always_comb begin
        data = mem_data;
        if (!run) begin
            data = '0;
        end else if (ZERO_REG && (addr == '0)) begin
            data = '0;
        end else if (BYPASS && wr_en && (addr == wr_addr)) begin
            data = wr_data;
        end
    end

endmodule

// File: rtl/regfile_bypass.sv
// Multi-port register file with a zeroing sweep after reset or on request,
// optional hardwired x0 and optional same-cycle write forwarding.
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int unsigned ADDRSIZE = REGADDR,
    parameter int unsigned WORDSIZE = XLEN,
    parameter int unsigned NREAD    = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_req,
    output logic                         ready,
    input  logic                         regwr,
    input  logic [ADDRSIZE-1:0]          rd,
    input  logic [WORDSIZE-1:0]          rddata,
    input  logic [NREAD*ADDRSIZE-1:0]    rs_addr,
    output logic [NREAD*WORDSIZE-1:0]   rs_data
);

    localparam int unsigned RFSIZE = 1 << ADDRSIZE;

    rf_state_e           state_q;
    logic [ADDRSIZE-1:0] clr_cnt_q;
    logic [WORDSIZE-1:0] mem [RFSIZE];

    logic run;
    logic wr_commit;

    assign run = (state_q == RUN);
    // An accepted clear request wins over a write in the same cycle; x0 writes are discarded.
    assign wr_commit = run && regwr && !clr_req && !(ZERO_REG && (rd == '0));

    // Sweep/run controller with registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            ready     <= 1'b0;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == ADDRSIZE'(RFSIZE - 1)) begin
                        state_q <= RUN;
                        ready   <= 1'b1;
                    end
                end
                RUN: begin
                    if (clr_req) begin
                        state_q   <= CLEAR;
                        clr_cnt_q <= '0;
                        ready     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    // Storage is never reset directly; the sweep zeroes one entry per cycle.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_commit) begin
            mem[rd] <= rddata;
        end
    end

    // Read ports share the write-side signals for forwarding.
    for (genvar k = 0; k < NREAD; k++) begin : g_rdport
        logic [ADDRSIZE-1:0] port_addr;
        assign port_addr = rs_addr[k*ADDRSIZE +: ADDRSIZE];

        regfile_rdport #(
            .ADDRSIZE (ADDRSIZE),
            .WORDSIZE (WORDSIZE),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rdport (
            .run      (run),
            .addr     (port_addr),
            .wr_en    (run && regwr),
            .wr_addr  (rd),
            .wr_data  (rddata),
            .mem_data (mem[port_addr]),
            .data     (rs_data[k*WORDSIZE +: WORDSIZE])
        );
    end

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: one bypassing and one non-bypassing instance share stimulus.
module tb_regfile_bypass;

    logic         clk;
    logic         rst_n;
    logic         clr_req;
    logic         regwr;
    logic [4:0]   rd;
    logic [63:0]  rddata;
    logic [9:0]   rs_addr;
    logic         ready;
    logic         ready_nb;
    logic [127:0] rs_data;
    logic [127:0] rs_data_nb;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        int          port;
        bit          nb;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];

    regfile_bypass dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .ready   (ready),
        .regwr   (regwr),
        .rd      (rd),
        .rddata  (rddata),
        .rs_addr (rs_addr),
        .rs_data (rs_data)
    );

    regfile_bypass #(.BYPASS(1'b0)) dut_nb (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .ready   (ready_nb),
        .regwr   (regwr),
        .rd      (rd),
        .rddata  (rddata),
        .rs_addr (rs_addr),
        .rs_data (rs_data_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [4:0] a0, input logic [4:0] a1);
        rs_addr = {a1, a0};
    endtask

    task automatic push_exp(input string tag, input int port, input bit nb, input logic [63:0] val);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.nb   = nb;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [63:0] got;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = e.nb ? rs_data_nb[e.port*64 +: 64] : rs_data[e.port*64 +: 64];
            tests++;
            assert (got === e.val) else begin
                fails++;
                $error("FAIL %s port%0d nb=%0d: got %h, expected %h", e.tag, e.port, e.nb, got, e.val);
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check_all();
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        tests++;
        assert (ready === exp && ready_nb === exp) else begin
            fails++;
            $error("FAIL %s: got ready=%b/%b, expected %b", tag, ready, ready_nb, exp);
        end
    endtask

    // Counts rising edges until ready rises; bounded so a stuck DUT still reaches the summary.
    task automatic wait_ready(input string tag, input int exp_n);
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        tests++;
        assert (n === exp_n) else begin
            fails++;
            $error("FAIL %s: got %0d cycles to ready, expected %0d", tag, n, exp_n);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        clr_req = 1'b0;
        regwr   = 1'b0;
        rd      = '0;
        rddata  = '0;
        set_addr(5'd1, 5'd2);
        tick();
        tick();

        // Reset state and post-reset sweep.
        chk_ready("reset_ready", 1'b0);
        push_exp("reset_read", 0, 1'b0, 64'h0);
        push_exp("reset_read", 1, 1'b1, 64'h0);
        check_all();
        rst_n = 1'b1;
        wait_ready("reset_sweep", 32);
        for (int i = 0; i < 32; i++) begin
            set_addr(5'(i), 5'(31 - i));
            push_exp("swept_read", 0, 1'b0, 64'h0);
            push_exp("swept_read", 1, 1'b0, 64'h0);
            sample();
        end

        // Write then read back; an untouched neighbour stays zero.
        tick();
        regwr  = 1'b1;
        rd     = 5'd5;
        rddata = 64'hDEAD_BEEF_0123_4567;
        set_addr(5'd0, 5'd0);
        tick();
        regwr = 1'b0;
        set_addr(5'd5, 5'd6);
        push_exp("wr_rd_x5", 0, 1'b0, 64'hDEAD_BEEF_0123_4567);
        push_exp("wr_rd_x6", 1, 1'b0, 64'h0);
        push_exp("wr_rd_x5_nb", 0, 1'b1, 64'hDEAD_BEEF_0123_4567);
        sample();
        set_addr(5'd5, 5'd5);
        push_exp("same_idx", 0, 1'b0, 64'hDEAD_BEEF_0123_4567);
        push_exp("same_idx", 1, 1'b0, 64'hDEAD_BEEF_0123_4567);
        sample();

        // Same-cycle forwarding vs stored value.
        tick();
        regwr  = 1'b1;
        rd     = 5'd7;
        rddata = 64'h55;
        set_addr(5'd5, 5'd7);
        push_exp("bypass_hit", 1, 1'b0, 64'h55);
        push_exp("nobypass_old", 1, 1'b1, 64'h0);
        push_exp("bypass_other", 0, 1'b0, 64'hDEAD_BEEF_0123_4567);
        sample();
        tick();
        regwr = 1'b0;
        push_exp("after_wr_x7", 1, 1'b0, 64'h55);
        push_exp("after_wr_x7_nb", 1, 1'b1, 64'h55);
        sample();

        // x0 is hardwired, including during a write to it.
        tick();
        regwr  = 1'b1;
        rd     = 5'd0;
        rddata = 64'hFF;
        set_addr(5'd0, 5'd0);
        push_exp("x0_bypass", 0, 1'b0, 64'h0);
        push_exp("x0_bypass", 1, 1'b0, 64'h0);
        sample();
        tick();
        regwr = 1'b0;
        push_exp("x0_stored", 0, 1'b0, 64'h0);
        push_exp("x0_stored", 1, 1'b1, 64'h0);
        sample();

        // Clear request collides with a write to x3; clr_req held into CLEAR must not restart it.
        tick();
        regwr   = 1'b1;
        rd      = 5'd3;
        rddata  = 64'h9;
        clr_req = 1'b1;
        set_addr(5'd3, 5'd3);
        tick();
        regwr = 1'b0;
        chk_ready("clr_ready_drop", 1'b0);
        push_exp("clear_read", 0, 1'b0, 64'h0);
        push_exp("clear_read", 1, 1'b1, 64'h0);
        sample();
        repeat (5) tick();
        clr_req = 1'b0;
        regwr   = 1'b1;
        rd      = 5'd2;
        rddata  = 64'hAB;
        tick();
        regwr = 1'b0;
        wait_ready("clr_sweep", 26);
        set_addr(5'd3, 5'd2);
        push_exp("clr_x3", 0, 1'b0, 64'h0);
        push_exp("clr_wr_in_clear_x2", 1, 1'b0, 64'h0);
        push_exp("clr_x3_nb", 0, 1'b1, 64'h0);
        sample();
        set_addr(5'd5, 5'd7);
        push_exp("clr_x5", 0, 1'b0, 64'h0);
        push_exp("clr_x7", 1, 1'b0, 64'h0);
        sample();

        // Reset partway through a sweep restarts it from entry 0.
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk_ready("midsweep_rst_ready", 1'b0);
        push_exp("midsweep_rst_read", 0, 1'b0, 64'h0);
        check_all();
        rst_n = 1'b1;
        wait_ready("midsweep_rst_sweep", 32);

        // File is usable again after the restarted sweep.
        regwr  = 1'b1;
        rd     = 5'd9;
        rddata = 64'h1234_5678_9ABC_DEF0;
        tick();
        regwr = 1'b0;
        set_addr(5'd9, 5'd10);
        push_exp("post_rst_x9", 0, 1'b0, 64'h1234_5678_9ABC_DEF0);
        push_exp("post_rst_x10", 1, 1'b0, 64'h0);
        sample();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
